// File: rtl/product_accumulator.sv
// Product accumulator: sums a programmed number of signed multiplier products
// into a wide signed accumulator. Define PRODUCT_ACC_SATURATE_EN to clamp on overflow instead of wrapping.
module product_accumulator #(
   parameter int PROD_W = 64,
   parameter int ACC_W  = 72,
   parameter int CNT_W  = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [CNT_W-1:0]  count,
   input  logic [PROD_W-1:0] product,
   input  logic              mul_overflow,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [ACC_W-1:0]  acc_out,
   output logic              acc_overflow,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              busy
);

   // state | meaning
   // IDLE  | waiting for start
   // ACCUM | accepting products until remaining reaches zero
   // DONE  | result held until out_ready
   typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

   state_t            state, state_nxt;
   logic [CNT_W-1:0]  remaining;
   logic              beat;
   logic [ACC_W-1:0]  prod_ext, sum, acc_nxt;
   logic              add_ovf;

   generate
      if (ACC_W > PROD_W) begin : g_ext
         assign prod_ext = {{(ACC_W-PROD_W){product[PROD_W-1]}}, product};
      end else begin : g_noext
         assign prod_ext = product[ACC_W-1:0];
      end
   endgenerate

   assign beat    = in_valid && in_ready;
   assign sum     = acc_out + prod_ext;
   // Signed overflow: both operands share a sign the result does not.
   assign add_ovf = (acc_out[ACC_W-1] == prod_ext[ACC_W-1]) && (sum[ACC_W-1] != acc_out[ACC_W-1]);

`ifdef PRODUCT_ACC_SATURATE_EN
   assign acc_nxt = !add_ovf ? sum :
                    acc_out[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
`else
   assign acc_nxt = sum;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = (count != '0) ? ACCUM : DONE;
         ACCUM:   if (beat && remaining == CNT_W'(1)) state_nxt = DONE;
         DONE:    if (out_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      in_ready  = (state == ACCUM);
      out_valid = (state == DONE);
      busy      = (state == ACCUM) || (state == DONE);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         acc_out      <= '0;
         acc_overflow <= 1'b0;
         remaining    <= '0;
      end else if (state == IDLE && start) begin
         acc_out      <= '0;
         acc_overflow <= 1'b0;
         remaining    <= count;
      end else if (beat) begin
         acc_out   <= acc_nxt;
         remaining <= remaining - CNT_W'(1);
         if (mul_overflow || add_ovf) acc_overflow <= 1'b1;
      end
   end

endmodule
